// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: divider state encoding and the
// fixed operand widths used by the sequential signed divider.
package arith_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER_N     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes. The top level
// reuses this single instance once per cycle to build the quotient MSB first.
module div_step
    import arith_pkg::*;
(
    input  logic [DIVISOR_W:0]   remIn_i,
    input  logic                 dividendBit_i,
    input  logic [DIVISOR_W-1:0] absB_i,
    output logic [DIVISOR_W:0]   remOut_o,
    output logic                 qBit_o
);

    logic [DIVISOR_W+1:0] trial;
    logic [DIVISOR_W:0]   diff;

    // Shift the next dividend bit in, compare against the divisor and either
    // keep the difference or restore the shifted remainder.
    always_comb begin
        trial    = {remIn_i, dividendBit_i};
        diff     = trial[DIVISOR_W:0] - {1'b0, absB_i};
        qBit_o   = (trial >= {2'b00, absB_i});
        remOut_o = qBit_o ? diff : trial[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 16-bit dividend by 8-bit divisor, quotient
// truncated toward zero, remainder taking the dividend's sign. Operands are
// reduced to magnitudes at acceptance, divided over 16 cycles, then sign-fixed.
module seq_signed_divider
    import arith_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotientBus,
    output logic [DIVISOR_W-1:0]  remainderBus,
    output logic                  divByZero,
    output logic                  overflow
);

    localparam logic [3:0] LAST_ITER = 4'(ITER_N - 1);

    div_state_t            state_q;
    logic [DIVIDEND_W-1:0] absA_q;
    logic [DIVISOR_W-1:0]  absB_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [3:0]            cnt_q;
    logic                  signQ_q;
    logic                  signR_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  remOut_q;
    logic                  divByZero_q;
    logic                  overflow_q;

    logic [DIVISOR_W:0]    rem_d;
    logic                  qBit_d;

    div_step u_step (
        .remIn_i       (rem_q),
        .dividendBit_i (absA_q[DIVIDEND_W-1]),
        .absB_i        (absB_q),
        .remOut_o      (rem_d),
        .qBit_o        (qBit_d)
    );

    // Control FSM plus datapath registers. absA_q doubles as the dividend
    // shift register: dividend bits leave at the top while quotient bits enter
    // at the bottom, so after the last step it holds the quotient magnitude.
    // A zero divisor still runs the full loop so latency never depends on data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            absA_q      <= '0;
            absB_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            signQ_q     <= 1'b0;
            signR_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quot_q      <= '0;
            remOut_q    <= '0;
            divByZero_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        absA_q  <= a[DIVIDEND_W-1] ? (~a + 16'd1) : a;
                        absB_q  <= b[DIVISOR_W-1] ? (~b + 8'd1) : b;
                        signQ_q <= a[DIVIDEND_W-1] ^ b[DIVISOR_W-1];
                        signR_q <= a[DIVIDEND_W-1];
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q  <= rem_d;
                    absA_q <= {absA_q[DIVIDEND_W-2:0], qBit_d};
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (absB_q == '0) begin
                        quot_q      <= '0;
                        remOut_q    <= '0;
                        divByZero_q <= 1'b1;
                        overflow_q  <= 1'b0;
                    end else begin
                        quot_q      <= signQ_q ? (~absA_q + 16'd1) : absA_q;
                        remOut_q    <= signR_q ? (~rem_q[DIVISOR_W-1:0] + 8'd1)
                                               : rem_q[DIVISOR_W-1:0];
                        divByZero_q <= 1'b0;
                        overflow_q  <= ~signQ_q & absA_q[DIVIDEND_W-1];
                    end
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign quotientBus  = quot_q;
    assign remainderBus = remOut_q;
    assign divByZero    = divByZero_q;
    assign overflow     = overflow_q;

endmodule
